// File: rtl/tpu_skew_feeder.sv
// Operand skew feeder for an NxN systolic array: snapshots A/B on start, streams
// A rows west and B columns north with diagonal skew, drains, then pulses done.
module tpu_skew_feeder #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   localparam int TC_W  = $clog2(2*N+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W*N*N-1:0] a_flat,
   input  logic [DATA_W*N*N-1:0] b_flat,
   output logic [DATA_W*N-1:0]   a_west_flat,
   output logic [DATA_W*N-1:0]   b_north_flat,
   output logic                  clear_acc,
   output logic                  stream_valid,
   output logic                  busy,
   output logic                  done,
   output logic [TC_W-1:0]       t_ctr
);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [TC_W-1:0]       r_t_ctr;
   logic [TC_W-1:0]       w_t_nxt;
   logic [DATA_W*N*N-1:0] r_snap_a;
   logic [DATA_W*N*N-1:0] r_snap_b;
   logic                  w_accept;

   assign w_accept = start & ~rst & ((r_state == S_IDLE) | (r_state == S_DONE));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_t_ctr  <= '0;
         r_snap_a <= '0;
         r_snap_b <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_t_ctr <= w_t_nxt;
         if (w_accept) begin
            r_snap_a <= a_flat;
            r_snap_b <= b_flat;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t_ctr;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_STREAM;
               w_t_nxt     = '0;
            end
         end
         S_STREAM: begin
            if (r_t_ctr == TC_W'(2*N-1)) begin
               w_state_nxt = S_DRAIN;
               w_t_nxt     = '0;
            end else begin
               w_t_nxt = r_t_ctr + 1'b1;
            end
         end
         S_DRAIN: begin
            if (r_t_ctr == TC_W'(N-1)) begin
               w_state_nxt = S_DONE;
               w_t_nxt     = '0;
            end else begin
               w_t_nxt = r_t_ctr + 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = w_accept ? S_STREAM : S_IDLE;
            w_t_nxt     = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_t_nxt     = '0;
         end
      endcase
   end

   // Lane i at time t carries element k where t == i + k; matching on the sum
   // avoids any t-i subtraction and its wrap-around for t < i.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_W-1:0] w_a;
      logic [DATA_W-1:0] w_b;
      always_comb begin
         w_a = '0;
         w_b = '0;
         if (r_state == S_STREAM) begin
            for (int k = 0; k < N; k++) begin
               if (r_t_ctr == TC_W'(i + k)) begin
                  w_a = r_snap_a[(i*N + k)*DATA_W +: DATA_W];
                  w_b = r_snap_b[(k*N + i)*DATA_W +: DATA_W];
               end
            end
         end
      end
      assign a_west_flat[i*DATA_W +: DATA_W]  = w_a;
      assign b_north_flat[i*DATA_W +: DATA_W] = w_b;
   end

   assign clear_acc    = w_accept;
   assign stream_valid = (r_state == S_STREAM);
   assign busy         = (r_state == S_STREAM) | (r_state == S_DRAIN);
   assign done         = (r_state == S_DONE);
   assign t_ctr        = r_t_ctr;

endmodule
